// File: rtl/sys_bus_pkg.sv
// Shared helpers for the sys_bus crossbar.
package sys_bus_pkg;

    // Width of a select index over n ports; never narrower than one bit so
    // a single-port bus still has a legal select register.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sys_bus.sv
// sys_bus: fixed-priority, single-cycle crossbar between NrHosts masters and
// NrDevices memory-mapped slaves on the req/gnt/rvalid protocol. Request
// routing is combinational; the response is steered by the host/device
// selection captured on the previous clock edge.
module sys_bus
    import sys_bus_pkg::*;
#(
    parameter int NrDevices    = 1,
    parameter int NrHosts      = 1,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,

    input  logic                      host_req_i     [NrHosts],
    output logic                      host_gnt_o     [NrHosts],
    input  logic [AddressWidth-1:0]   host_addr_i    [NrHosts],
    input  logic                      host_we_i      [NrHosts],
    input  logic [DataWidth/8-1:0]    host_be_i      [NrHosts],
    input  logic [DataWidth-1:0]      host_wdata_i   [NrHosts],
    output logic                      host_rvalid_o  [NrHosts],
    output logic [DataWidth-1:0]      host_rdata_o   [NrHosts],
    output logic                      host_err_o     [NrHosts],

    output logic                      device_req_o   [NrDevices],
    output logic [AddressWidth-1:0]   device_addr_o  [NrDevices],
    output logic                      device_we_o    [NrDevices],
    output logic [DataWidth/8-1:0]    device_be_o    [NrDevices],
    output logic [DataWidth-1:0]      device_wdata_o [NrDevices],
    input  logic                      device_rvalid_i[NrDevices],
    input  logic [DataWidth-1:0]      device_rdata_i [NrDevices],
    input  logic                      device_err_i   [NrDevices],

    input  logic [AddressWidth-1:0]   cfg_device_addr_base[NrDevices],
    input  logic [AddressWidth-1:0]   cfg_device_addr_mask[NrDevices]
);

    localparam int unsigned HostIdxW = sel_width(NrHosts);
    localparam int unsigned DevIdxW  = sel_width(NrDevices);

    logic [HostIdxW-1:0]     host_sel_d, host_sel_q;
    logic [DevIdxW-1:0]      dev_sel_d, dev_sel_q;
    logic                    unmapped_d, unmapped_q;
    logic                    dev_match;

    logic                    sel_req;
    logic [AddressWidth-1:0] sel_addr;
    logic                    sel_we;
    logic [DataWidth/8-1:0]  sel_be;
    logic [DataWidth-1:0]    sel_wdata;

    // Fixed-priority arbiter: scanning downwards lets the lowest requester win.
    always_comb begin
        host_sel_d = '0;
        for (int i = NrHosts - 1; i >= 0; i--) begin
            if (host_req_i[i]) begin
                host_sel_d = HostIdxW'(i);
            end
        end
    end

    assign sel_req   = host_req_i[host_sel_d];
    assign sel_addr  = host_addr_i[host_sel_d];
    assign sel_we    = host_we_i[host_sel_d];
    assign sel_be    = host_be_i[host_sel_d];
    assign sel_wdata = host_wdata_i[host_sel_d];

    // Address decoder: lowest-index matching region wins; no match means unmapped.
    always_comb begin
        dev_sel_d = '0;
        dev_match = 1'b0;
        for (int i = NrDevices - 1; i >= 0; i--) begin
            if ((sel_addr & cfg_device_addr_mask[i]) == cfg_device_addr_base[i]) begin
                dev_sel_d = DevIdxW'(i);
                dev_match = 1'b1;
            end
        end
    end

    // Only a real request to an unmapped address produces an error response.
    assign unmapped_d = sel_req & ~dev_match;

    // Capture the routing of this cycle so next cycle's response finds its host.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            host_sel_q <= '0;
            dev_sel_q  <= '0;
            unmapped_q <= 1'b0;
        end else begin
            host_sel_q <= host_sel_d;
            dev_sel_q  <= dev_sel_d;
            unmapped_q <= unmapped_d;
        end
    end

    genvar gi;

    // Per-host grant and response steering.
    generate
        for (gi = 0; gi < NrHosts; gi++) begin : g_host
            logic is_granted;
            logic is_resp_owner;

            assign is_granted         = (host_sel_d == HostIdxW'(gi));
            assign is_resp_owner      = (host_sel_q == HostIdxW'(gi));
            assign host_gnt_o[gi]     = is_granted & host_req_i[gi];
            assign host_rvalid_o[gi]  = is_resp_owner & (unmapped_q | device_rvalid_i[dev_sel_q]);
            assign host_err_o[gi]     = is_resp_owner & (unmapped_q | device_err_i[dev_sel_q]);
            assign host_rdata_o[gi]   = (is_resp_owner & ~unmapped_q) ? device_rdata_i[dev_sel_q]
                                                                      : '0;
        end
    endgenerate

    // Per-device forwarding; everything not addressed is held at zero.
    generate
        for (gi = 0; gi < NrDevices; gi++) begin : g_dev
            logic hit;

            assign hit                = dev_match & (dev_sel_d == DevIdxW'(gi));
            assign device_req_o[gi]   = hit & sel_req;
            assign device_addr_o[gi]  = hit ? sel_addr  : '0;
            assign device_we_o[gi]    = hit & sel_we;
            assign device_be_o[gi]    = hit ? sel_be    : '0;
            assign device_wdata_o[gi] = hit ? sel_wdata : '0;
        end
    endgenerate

endmodule

// File: tb/tb_sys_bus.sv
// Self-checking bench for sys_bus: two hosts, three devices (RAM, sim-ctrl,
// timer map). Directed scenarios followed by randomized traffic, all checked
// against a transaction-level reference model.
module tb_sys_bus;

    localparam int NH = 2;
    localparam int ND = 3;
    localparam int DW = 32;
    localparam int AW = 32;

    localparam int KIND_DEV  = 0;  // a device owes the registered host a response
    localparam int KIND_UNM  = 1;  // the bus itself owes an error response
    localparam int KIND_IDLE = 2;  // nothing outstanding

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    logic          h_req   [NH];
    logic          h_gnt   [NH];
    logic [AW-1:0] h_addr  [NH];
    logic          h_we    [NH];
    logic [3:0]    h_be    [NH];
    logic [DW-1:0] h_wdata [NH];
    logic          h_rvalid[NH];
    logic [DW-1:0] h_rdata [NH];
    logic          h_err   [NH];

    logic          d_req   [ND];
    logic [AW-1:0] d_addr  [ND];
    logic          d_we    [ND];
    logic [3:0]    d_be    [ND];
    logic [DW-1:0] d_wdata [ND];
    logic          d_rvalid[ND];
    logic [DW-1:0] d_rdata [ND];
    logic          d_err   [ND];

    logic [AW-1:0] cfg_base[ND];
    logic [AW-1:0] cfg_mask[ND];

    int checks = 0;
    int errors = 0;

    // Reference model: who is owed a response next cycle, and by whom.
    int p_host;
    int p_dev;
    int p_kind;

    sys_bus #(
        .NrDevices   (ND),
        .NrHosts     (NH),
        .DataWidth   (DW),
        .AddressWidth(AW)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_ni),
        .host_req_i          (h_req),
        .host_gnt_o          (h_gnt),
        .host_addr_i         (h_addr),
        .host_we_i           (h_we),
        .host_be_i           (h_be),
        .host_wdata_i        (h_wdata),
        .host_rvalid_o       (h_rvalid),
        .host_rdata_o        (h_rdata),
        .host_err_o          (h_err),
        .device_req_o        (d_req),
        .device_addr_o       (d_addr),
        .device_we_o         (d_we),
        .device_be_o         (d_be),
        .device_wdata_o      (d_wdata),
        .device_rvalid_i     (d_rvalid),
        .device_rdata_i      (d_rdata),
        .device_err_i        (d_err),
        .cfg_device_addr_base(cfg_base),
        .cfg_device_addr_mask(cfg_mask)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Memory map lookup: first region containing the address, -1 if none.
    function automatic int region_of(input logic [AW-1:0] a);
        for (int d = 0; d < ND; d++) begin
            if ((a & cfg_mask[d]) == cfg_base[d]) return d;
        end
        return -1;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        case ($urandom % 4)
            0:       return 32'h0010_0000 | ($urandom & 32'h000F_FFFF);
            1:       return 32'h0002_0000 | ($urandom & 32'h0000_03FF);
            2:       return 32'h0003_0000 | ($urandom & 32'h0000_03FF);
            default: return $urandom;
        endcase
    endfunction

    task automatic reset_model();
        p_host = 0;
        p_dev  = 0;
        p_kind = KIND_DEV;
    endtask

    // One bus cycle. Entered just after a falling edge with host inputs set.
    // rd/er are what the responding device returns this cycle.
    task automatic cycle(input logic [31:0] rd, input logic er, output int granted);
        int            hsel;
        int            dsel;
        logic          any;
        logic          hit;
        logic          e_rv;
        logic          e_er;
        logic [DW-1:0] e_rd;

        // Device side: the owing device answers; bystanders drive noise.
        for (int d = 0; d < ND; d++) begin
            if (p_kind == KIND_IDLE) begin
                d_rvalid[d] = 1'b0;
                d_rdata[d]  = '0;
                d_err[d]    = 1'b0;
            end else begin
                d_rvalid[d] = 1'($urandom % 2);
                d_rdata[d]  = $urandom;
                d_err[d]    = 1'($urandom % 2);
            end
        end
        if (p_kind == KIND_DEV) begin
            d_rvalid[p_dev] = 1'b1;
            d_rdata[p_dev]  = rd;
            d_err[p_dev]    = er;
        end
        #2;

        // Transaction offered this cycle.
        hsel = 0;
        any  = 1'b0;
        for (int h = NH - 1; h >= 0; h--) begin
            if (h_req[h]) begin
                hsel = h;
                any  = 1'b1;
            end
        end
        dsel    = region_of(h_addr[hsel]);
        granted = any ? hsel : -1;

        for (int h = 0; h < NH; h++) begin
            chk($sformatf("gnt[%0d]", h), 32'(h_gnt[h]), 32'(any && h == hsel));
        end
        for (int d = 0; d < ND; d++) begin
            hit = (d == dsel);
            chk($sformatf("dev_req[%0d]", d),   32'(d_req[d]), 32'(hit && any));
            chk($sformatf("dev_addr[%0d]", d),  d_addr[d],     hit ? h_addr[hsel] : 32'h0);
            chk($sformatf("dev_we[%0d]", d),    32'(d_we[d]),  32'(hit && h_we[hsel]));
            chk($sformatf("dev_be[%0d]", d),    32'(d_be[d]),  hit ? 32'(h_be[hsel]) : 32'h0);
            chk($sformatf("dev_wdata[%0d]", d), d_wdata[d],    hit ? h_wdata[hsel] : 32'h0);
        end

        // Response owed from the previous cycle.
        for (int h = 0; h < NH; h++) begin
            e_rv = 1'b0;
            e_er = 1'b0;
            e_rd = '0;
            if (h == p_host && p_kind == KIND_UNM) begin
                e_rv = 1'b1;
                e_er = 1'b1;
            end else if (h == p_host && p_kind == KIND_DEV) begin
                e_rv = d_rvalid[p_dev];
                e_er = d_err[p_dev];
                e_rd = d_rdata[p_dev];
            end
            chk($sformatf("rvalid[%0d]", h), 32'(h_rvalid[h]), 32'(e_rv));
            chk($sformatf("rdata[%0d]", h),  h_rdata[h],       e_rd);
            chk($sformatf("err[%0d]", h),    32'(h_err[h]),    32'(e_er));
        end

        @(posedge clk);
        if (!rst_ni) begin
            reset_model();
        end else begin
            p_host = hsel;
            p_dev  = (dsel < 0) ? 0 : dsel;
            p_kind = !any ? KIND_IDLE : ((dsel < 0) ? KIND_UNM : KIND_DEV);
        end
        @(negedge clk);
    endtask

    task automatic set_host(input int h, input logic req, input logic [AW-1:0] a,
                            input logic we, input logic [3:0] be, input logic [DW-1:0] wd);
        h_req[h]   = req;
        h_addr[h]  = a;
        h_we[h]    = we;
        h_be[h]    = be;
        h_wdata[h] = wd;
    endtask

    initial begin
        int   g;
        logic won[NH];

        cfg_base[0] = 32'h0010_0000; cfg_mask[0] = ~32'h000F_FFFF;
        cfg_base[1] = 32'h0002_0000; cfg_mask[1] = ~32'h0000_03FF;
        cfg_base[2] = 32'h0003_0000; cfg_mask[2] = ~32'h0000_03FF;
        for (int h = 0; h < NH; h++) set_host(h, 1'b0, '0, 1'b0, 4'h0, '0);
        for (int d = 0; d < ND; d++) begin
            d_rvalid[d] = 1'b0;
            d_rdata[d]  = '0;
            d_err[d]    = 1'b0;
        end
        reset_model();

        @(negedge clk);
        // In reset: host 0 sees device 0 passed straight through.
        cycle(32'h0BAD_F00D, 1'b0, g);
        rst_ni = 1'b1;
        cycle(32'h1111_2222, 1'b1, g);

        // RAM read, answered with DEADBEEF.
        set_host(0, 1'b1, 32'h0010_0010, 1'b0, 4'hF, '0);
        cycle($urandom, 1'b0, g);
        set_host(0, 1'b0, '0, 1'b0, 4'h0, '0);
        cycle(32'hDEAD_BEEF, 1'b0, g);

        // Write to device 1.
        set_host(0, 1'b1, 32'h0002_0008, 1'b1, 4'hF, 32'h0000_0041);
        cycle($urandom, 1'b0, g);
        set_host(0, 1'b0, '0, 1'b0, 4'h0, '0);
        cycle(32'h0, 1'b0, g);

        // Unmapped address, then its error response.
        set_host(0, 1'b1, 32'h0005_0000, 1'b0, 4'hF, '0);
        cycle($urandom, 1'b0, g);
        set_host(0, 1'b0, '0, 1'b0, 4'h0, '0);
        cycle($urandom, 1'b0, g);

        // Device 2 returns an error.
        set_host(0, 1'b1, 32'h0003_0004, 1'b0, 4'hF, '0);
        cycle($urandom, 1'b0, g);
        set_host(0, 1'b0, '0, 1'b0, 4'h0, '0);
        cycle(32'h0000_7777, 1'b1, g);

        // Simultaneous requests: host 0 wins, host 1 holds and goes next.
        set_host(0, 1'b1, 32'h0010_0000, 1'b0, 4'hF, '0);
        set_host(1, 1'b1, 32'h0003_0000, 1'b0, 4'h3, '0);
        cycle($urandom, 1'b0, g);
        set_host(0, 1'b0, '0, 1'b0, 4'h0, '0);
        cycle(32'hA5A5_0000, 1'b0, g);
        set_host(1, 1'b0, '0, 1'b0, 4'h0, '0);
        cycle(32'h5A5A_1111, 1'b0, g);

        // Back-to-back reads, then reset with a response pending.
        set_host(0, 1'b1, 32'h0010_0020, 1'b0, 4'hF, '0);
        cycle($urandom, 1'b0, g);
        set_host(0, 1'b1, 32'h0003_0010, 1'b0, 4'hF, '0);
        cycle(32'h0000_0D00, 1'b0, g);
        set_host(0, 1'b1, 32'h0010_0040, 1'b0, 4'hF, '0);
        rst_ni = 1'b0;
        #1;
        reset_model();
        cycle(32'h0000_0E00, 1'b0, g);
        rst_ni = 1'b1;
        set_host(0, 1'b0, '0, 1'b0, 4'h0, '0);
        cycle(32'h0000_0F00, 1'b0, g);

        // Randomized traffic; a losing host holds its request until granted.
        for (int h = 0; h < NH; h++) won[h] = 1'b1;
        for (int n = 0; n < 400; n++) begin
            for (int h = 0; h < NH; h++) begin
                if (!(h_req[h] && !won[h])) begin
                    set_host(h, ($urandom % 5) < 3, rand_addr(), 1'($urandom % 2),
                             4'($urandom), $urandom);
                end
            end
            cycle($urandom, 1'($urandom % 2), g);
            for (int h = 0; h < NH; h++) won[h] = (g == h);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
